// File: rtl/data_mem_responder.sv
// Word-wide data memory serving CPU load/store requests over req/ack with LATENCY wait states.
// Optional DATA_MEM_RESPONDER_ALIGN_CHECK_EN: misaligned requests complete with err=1 and no access.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    // state | meaning
    // IDLE  | waiting for req; ack=0, busy=0
    // WAIT  | request captured, counting down wait cycles
    // RESP  | access performed on entry; ack=1, busy=1 for one cycle

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       wait_cnt, wait_cnt_nxt;
    logic             cap_wr;
    logic [31:0]      cap_addr, cap_wdata;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept, enter_resp;
    logic             acc_wr;
    logic [31:0]      acc_addr, acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_misaligned, cap_misaligned;
    logic             unused_addr_bits;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency the access happens on the accept edge, so use the live inputs.
    assign enter_resp = (state_nxt == RESP);
    assign acc_wr     = (state == IDLE) ? wr      : cap_wr;
    assign acc_addr   = (state == IDLE) ? address : cap_addr;
    assign acc_wdata  = (state == IDLE) ? wdata   : cap_wdata;
    assign acc_idx    = acc_addr[IDX_W+1:2];

`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
    assign acc_misaligned = |acc_addr[1:0];
    assign cap_misaligned = |cap_addr[1:0];
`else
    assign acc_misaligned = 1'b0;
    assign cap_misaligned = 1'b0;
`endif

    // Address bits above the array and the byte offset are deliberately not decoded.
    assign unused_addr_bits = ^{address[31:IDX_W+2], cap_addr[31:IDX_W+2],
                                address[1:0], cap_addr[1:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                cap_wr    <= wr;
                cap_addr  <= address;
                cap_wdata <= wdata;
            end
            if (enter_resp) begin
                if (acc_misaligned)  rdata <= '0;
                else if (acc_wr)     rdata <= acc_wdata;
                else                 rdata <= mem[acc_idx];
            end
        end
    end

    // Array is not reset, but reset still suppresses a write that would land on the same edge.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && acc_wr && !acc_misaligned) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);
    assign err  = (state == RESP) && cap_misaligned;

endmodule
